// File: rtl/dds_pkg.sv
// Shared constants, FSM state encoding and DAC frame packing for the DDS-to-DAC path.
package dds_pkg;

    localparam int         SAMPLE_W   = 10;
    localparam int         FRAME_W    = 16;
    localparam logic [3:0] CMD_NIBBLE = 4'b0001;
    localparam logic [9:0] MIDSCALE   = 10'h200;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BUSY,
        ST_GUARD
    } seq_state_t;

    // DAC command word: command nibble, sample, two don't-care LSBs held at zero
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [3:0] cmd,
                                                      input logic [SAMPLE_W-1:0] sample);
        return {cmd, sample, 2'b00};
    endfunction

endpackage

// File: rtl/dac_frame_seq_if.sv
// Sample stream plus SPI start/done handshake seen by the frame sequencer.
interface dac_frame_seq_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              spi_start;
    logic [15:0]       spi_data;
    logic              spi_done;

    modport master (
        input  s_data, s_valid, spi_done,
        output s_ready, spi_start, spi_data
    );

    modport slave (
        output s_data, s_valid, spi_done,
        input  s_ready, spi_start, spi_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with registered full/empty/level flags.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en & ~full_reg;
    assign do_rd = rd_en & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_wr, do_rd})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == (AW+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = empty_reg;
    assign level   = count_reg;

endmodule

// File: rtl/dac_frame_seq.sv
// Paces buffered DDS samples into DAC command frames and runs the SPI start/done
// handshake with a guard gap between frames; repeats the last word on underflow.
module dac_frame_seq
    import dds_pkg::*;
#(
    parameter int         DATA_W   = SAMPLE_W,
    parameter logic [3:0] CMD      = CMD_NIBBLE,
    parameter int         GUARD    = 5,
    parameter int         DEPTH    = 4,
    parameter int         RATE_DIV = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dac_frame_seq_if.master        bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             underflow_cnt,
    output logic                   overrun
);
    // The IDLE cycle that follows GUARD is itself one of the idle cycles
    localparam int GUARD_HOLD = (GUARD > 1) ? GUARD - 1 : 0;
    localparam int GW         = (GUARD_HOLD > 1) ? $clog2(GUARD_HOLD) : 1;

    seq_state_t        state_reg;
    logic              pending_reg;
    logic              spi_start_reg;
    logic [15:0]       spi_data_reg;
    logic [7:0]        underflow_reg;
    logic              overrun_reg;
    logic [GW-1:0]     guard_cnt_reg;
    logic              tick;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rd_data;

    generate
        if (RATE_DIV == 0) begin : g_free_run
            assign tick = 1'b1;
        end else begin : g_rate
            localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
            logic [CW-1:0] rate_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rate_cnt_reg <= '0;
                else if (rate_cnt_reg == CW'(RATE_DIV - 1))
                    rate_cnt_reg <= '0;
                else
                    rate_cnt_reg <= rate_cnt_reg + CW'(1);
            end

            assign tick = (rate_cnt_reg == CW'(RATE_DIV - 1));
        end
    endgenerate

    assign fifo_pop = (state_reg == ST_IDLE) && pending_reg && !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.s_valid & ~fifo_full),
        .wr_data (bus.s_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pending_reg   <= 1'b1;
            spi_start_reg <= 1'b0;
            spi_data_reg  <= pack_frame(CMD, MIDSCALE);
            underflow_reg <= '0;
            overrun_reg   <= 1'b0;
            guard_cnt_reg <= '0;
        end else begin
            spi_start_reg <= 1'b0;
            // A tick landing on the LOAD cycle re-arms the next frame
            pending_reg   <= tick | (pending_reg & (state_reg != ST_LOAD));
            if (tick && pending_reg) overrun_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (pending_reg) begin
                        if (!fifo_empty)
                            spi_data_reg <= pack_frame(CMD, fifo_rd_data);
                        else if (underflow_reg != 8'hFF)
                            underflow_reg <= underflow_reg + 8'd1;
                        spi_start_reg <= 1'b1;
                        state_reg     <= ST_LOAD;
                    end
                end
                ST_LOAD: state_reg <= ST_BUSY;
                ST_BUSY: begin
                    if (bus.spi_done) begin
                        if (GUARD_HOLD == 0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            guard_cnt_reg <= GW'(GUARD_HOLD > 0 ? GUARD_HOLD - 1 : 0);
                            state_reg     <= ST_GUARD;
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt_reg == '0)
                        state_reg <= ST_IDLE;
                    else
                        guard_cnt_reg <= guard_cnt_reg - GW'(1);
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready    = ~fifo_full;
    assign bus.spi_start  = spi_start_reg;
    assign bus.spi_data   = spi_data_reg;
    assign underflow_cnt  = underflow_reg;
    assign overrun        = overrun_reg;

endmodule
